// File: rtl/line_buffer_sched.sv
// Line-buffer scheduler: rotates three line buffers, issues B/E reads and E write-backs.
// Optional input-sequence checker enabled by `define LINE_BUFFER_SCHED_SEQ_CHECK_EN.
module line_buffer_sched #(
    parameter int FRAME_WIDTH  = 240,
    parameter int FRAME_HEIGHT = 320,
    parameter int WB_LAG       = 3,
    parameter int RD_LAT       = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        pix_valid_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    output logic        in_ready,
    output logic [1:0]  fill_sel,
    output logic [7:0]  rd_addr,
    output logic [7:0]  wb_addr,
    output logic        wb_en,
    output logic        a_valid,
    output logic [10:0] a_hcount,
    output logic [9:0]  a_vcount,
    output logic        frame_done,
    output logic        seq_err
);

    localparam logic [10:0] LAST_COL   = 11'(FRAME_WIDTH - 1);
    localparam logic [10:0] LAG        = 11'(WB_LAG);
    localparam logic [10:0] TAIL_START = 11'(FRAME_WIDTH - WB_LAG);
    localparam logic [7:0]  LAG_CNT    = 8'(WB_LAG);
    localparam logic [9:0]  LAST_ROW   = 10'(FRAME_HEIGHT - 1);
    localparam logic [9:0]  FLUSH_ROW0 = 10'(FRAME_HEIGHT - 2);
    localparam logic [9:0]  PRIME_ROW  = 10'd1;

    typedef enum logic [2:0] {IDLE, PRIME, RUN, FLUSH, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  fill_sel_q, fill_sel_d;
    logic [9:0]  row_q, row_d;
    logic [10:0] flush_col_q, flush_col_d;
    logic [1:0]  sweep_q, sweep_d;
    logic [1:0]  last_sel_q, last_sel_d;
    logic [7:0]  tail_left_q, tail_left_d;
    logic [10:0] tail_col_q, tail_col_d;
    logic [1:0]  tail_sel_q, tail_sel_d;

    logic        pipe_vld_q [RD_LAT];
    logic        pipe_vld_d [RD_LAT];
    logic [10:0] pipe_col_q [RD_LAT];
    logic [10:0] pipe_col_d [RD_LAT];
    logic [9:0]  pipe_row_q [RD_LAT];
    logic [9:0]  pipe_row_d [RD_LAT];
    logic [1:0]  pipe_sel_q [RD_LAT];
    logic [1:0]  pipe_sel_d [RD_LAT];

    logic        accept, start_px, line_end, run_issue, flush_issue, flush_sweep_end;
    logic        issue, tail_active, tail_load, main_wb, last_wb;
    logic [10:0] issue_col, wb_col;
    logic [9:0]  issue_row;
    logic [1:0]  a_sel, wb_sel;

    assign accept          = pix_valid_in & in_ready;
    assign start_px        = accept & (state_q == IDLE) & (hcount_in == 11'd0) & (vcount_in == 10'd0);
    assign line_end        = accept & ((state_q == PRIME) | (state_q == RUN)) & (hcount_in == LAST_COL);
    assign run_issue       = accept & (state_q == RUN);
    assign flush_issue     = (state_q == FLUSH) & (sweep_q != 2'd2);
    assign flush_sweep_end = flush_issue & (flush_col_q == LAST_COL);
    assign issue           = run_issue | flush_issue;
    assign issue_col       = flush_issue ? flush_col_q : hcount_in;
    assign issue_row       = flush_issue ? (sweep_q[0] ? LAST_ROW : FLUSH_ROW0)
                                         : (vcount_in - 10'd2);

    assign a_valid  = pipe_vld_q[RD_LAT-1];
    assign a_hcount = pipe_col_q[RD_LAT-1];
    assign a_vcount = pipe_row_q[RD_LAT-1];
    assign a_sel    = pipe_sel_q[RD_LAT-1];
    assign fill_sel = fill_sel_q;

    // Tail columns of a line have no later read to piggy-back on, so a
    // dedicated counter writes them back using the buffer index of their line.
    assign tail_active = (tail_left_q != 8'd0);
    assign tail_load   = a_valid & (a_hcount == LAST_COL) & (WB_LAG > 0);
    assign main_wb     = a_valid & (a_hcount >= LAG);

    always_comb begin
        wb_col = 11'd0;
        wb_sel = a_sel;
        if (tail_active) begin
            wb_col = tail_col_q;
            wb_sel = tail_sel_q;
        end else if (main_wb) begin
            wb_col = a_hcount - LAG;
        end
    end

    assign wb_en   = tail_active | main_wb;
    assign wb_addr = wb_col[7:0];
    assign rd_addr = flush_issue ? flush_col_q[7:0] : (run_issue ? hcount_in[7:0] : 8'd0);
    assign last_wb = (state_q == FLUSH) & (sweep_q == 2'd2) & wb_en &
                     (wb_col == LAST_COL) & (wb_sel == last_sel_q);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_px) state_d = PRIME;
            PRIME:   if (line_end && row_q == PRIME_ROW) state_d = RUN;
            RUN:     if (line_end && row_q == LAST_ROW) state_d = FLUSH;
            FLUSH:   if (last_wb) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE, PRIME, RUN: in_ready = 1'b1;
            DONE:             frame_done = 1'b1;
            default:          in_ready = 1'b0;
        endcase
    end

    always_comb begin
        fill_sel_d  = fill_sel_q;
        row_d       = row_q;
        flush_col_d = flush_col_q;
        sweep_d     = sweep_q;
        last_sel_d  = last_sel_q;
        tail_left_d = tail_left_q;
        tail_col_d  = tail_col_q;
        tail_sel_d  = tail_sel_q;

        if (line_end || flush_sweep_end) begin
            fill_sel_d = (fill_sel_q == 2'd2) ? 2'd0 : fill_sel_q + 2'd1;
        end

        if (start_px) begin
            row_d = 10'd0;
        end else if (line_end) begin
            row_d = row_q + 10'd1;
        end

        if (state_q != FLUSH) begin
            flush_col_d = 11'd0;
            sweep_d     = 2'd0;
        end else if (flush_issue) begin
            if (flush_sweep_end) begin
                flush_col_d = 11'd0;
                sweep_d     = sweep_q + 2'd1;
                if (sweep_q == 2'd1) last_sel_d = fill_sel_q;
            end else begin
                flush_col_d = flush_col_q + 11'd1;
            end
        end

        if (tail_load) begin
            tail_left_d = LAG_CNT;
            tail_col_d  = TAIL_START;
            tail_sel_d  = a_sel;
        end else if (tail_active) begin
            tail_left_d = tail_left_q - 8'd1;
            tail_col_d  = tail_col_q + 11'd1;
        end

        pipe_vld_d[0] = issue;
        pipe_col_d[0] = issue ? issue_col : 11'd0;
        pipe_row_d[0] = issue ? issue_row : 10'd0;
        pipe_sel_d[0] = fill_sel_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_col_d[i] = pipe_col_q[i-1];
            pipe_row_d[i] = pipe_row_q[i-1];
            pipe_sel_d[i] = pipe_sel_q[i-1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fill_sel_q  <= 2'd0;
            row_q       <= 10'd0;
            flush_col_q <= 11'd0;
            sweep_q     <= 2'd0;
            last_sel_q  <= 2'd0;
            tail_left_q <= 8'd0;
            tail_col_q  <= 11'd0;
            tail_sel_q  <= 2'd0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_col_q[i] <= 11'd0;
                pipe_row_q[i] <= 10'd0;
                pipe_sel_q[i] <= 2'd0;
            end
        end else begin
            fill_sel_q  <= fill_sel_d;
            row_q       <= row_d;
            flush_col_q <= flush_col_d;
            sweep_q     <= sweep_d;
            last_sel_q  <= last_sel_d;
            tail_left_q <= tail_left_d;
            tail_col_q  <= tail_col_d;
            tail_sel_q  <= tail_sel_d;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_d[i];
                pipe_col_q[i] <= pipe_col_d[i];
                pipe_row_q[i] <= pipe_row_d[i];
                pipe_sel_q[i] <= pipe_sel_d[i];
            end
        end
    end

`ifdef LINE_BUFFER_SCHED_SEQ_CHECK_EN
    logic [10:0] prev_col_q, prev_col_d;
    logic [9:0]  prev_row_q, prev_row_d;
    logic        seq_err_q, seq_err_d;
    logic        in_line, bad_col, bad_row, bad_rdy;
    logic [10:0] exp_col;

    assign in_line = accept & ((state_q == PRIME) | (state_q == RUN));
    assign exp_col = (prev_col_q == LAST_COL) ? 11'd0 : prev_col_q + 11'd1;
    assign bad_col = in_line & (hcount_in != exp_col);
    assign bad_row = in_line & (vcount_in != prev_row_q) & (prev_col_q != LAST_COL);
    assign bad_rdy = pix_valid_in & ~in_ready;

    always_comb begin
        prev_col_d = prev_col_q;
        prev_row_d = prev_row_q;
        seq_err_d  = seq_err_q | bad_col | bad_row | bad_rdy;
        if (start_px || in_line) begin
            prev_col_d = hcount_in;
            prev_row_d = vcount_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            prev_col_q <= 11'd0;
            prev_row_q <= 10'd0;
            seq_err_q  <= 1'b0;
        end else begin
            prev_col_q <= prev_col_d;
            prev_row_q <= prev_row_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_line_buffer_sched.sv
// Scoreboard bench for line_buffer_sched on an 8x4 frame.
module tb_line_buffer_sched;
    localparam int FW  = 8;
    localparam int FH  = 4;
    localparam int LAG = 3;
    localparam int LAT = 2;
`ifdef LINE_BUFFER_SCHED_SEQ_CHECK_EN
    localparam int SEQ_EXP = 1;
`else
    localparam int SEQ_EXP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic [10:0] hcount = 11'd0;
    logic [9:0]  vcount = 10'd0;
    logic        in_ready, wb_en, a_valid, frame_done, seq_err;
    logic [1:0]  fill_sel;
    logic [7:0]  rd_addr, wb_addr;
    logic [10:0] a_hcount;
    logic [9:0]  a_vcount;

    line_buffer_sched #(.FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .WB_LAG(LAG), .RD_LAT(LAT)) dut (
        .clk_in(clk), .rst_in(rst), .pix_valid_in(pix_valid), .hcount_in(hcount),
        .vcount_in(vcount), .in_ready(in_ready), .fill_sel(fill_sel), .rd_addr(rd_addr),
        .wb_addr(wb_addr), .wb_en(wb_en), .a_valid(a_valid), .a_hcount(a_hcount),
        .a_vcount(a_vcount), .frame_done(frame_done), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int v;
        int c;
    } aexp_t;

    aexp_t aq[$];
    int    wq[$];
    int    n_total = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    done_cnt = 0;
    int    fs_exp = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops scoreboard entries whenever the DUT produces reads or write-backs.
    always @(negedge clk) begin
        aexp_t e;
        if (!rst) begin
            if (frame_done) done_cnt++;
            if (a_valid) begin
                if (aq.size() == 0) begin
                    check_val("a_unexp", int'(a_valid), 0);
                end else begin
                    e = aq.pop_front();
                    check_val("a_hcount", int'(a_hcount), e.h);
                    check_val("a_vcount", int'(a_vcount), e.v);
                    if (e.c >= 0) check_val("a_latency", cyc, e.c);
                end
                if (int'(a_hcount) >= LAG) begin
                    check_val("wb_en_main", int'(wb_en), 1);
                    check_val("wb_addr_main", int'(wb_addr), int'(a_hcount) - LAG);
                end
            end
            if (wb_en) begin
                if (wq.size() == 0) check_val("wb_unexp", int'(wb_en), 0);
                else check_val("wb_addr", int'(wb_addr), wq.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        pix_valid = 1'b0;
        hcount = 11'd0;
        vcount = 10'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        aq.delete();
        wq.delete();
        fs_exp = 0;
    endtask

    task automatic send_pix(input int c, input int r, input bit run);
        @(posedge clk);
        #1;
        pix_valid = 1'b1;
        hcount = 11'(c);
        vcount = 10'(r);
        if (run) begin
            aq.push_back('{h: c, v: r - 2, c: cyc + LAT});
            if (c == 0) for (int k = 0; k < FW; k++) wq.push_back(k);
        end
        @(negedge clk);
        check_val("fill_sel", int'(fill_sel), fs_exp % 3);
        check_val("in_ready", int'(in_ready), 1);
        if (run) check_val("rd_addr", int'(rd_addr), c);
        if (c == FW - 1) fs_exp++;
    endtask

    task automatic run_frame();
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 1'b0;
        for (int r = 0; r < FH; r++)
            for (int c = 0; c < FW; c++) send_pix(c, r, r >= 2);
        for (int r = FH - 2; r < FH; r++) begin
            for (int c = 0; c < FW; c++) aq.push_back('{h: c, v: r, c: -1});
            for (int c = 0; c < FW; c++) wq.push_back(c);
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        @(negedge clk);
        check_val("flush_in_ready", int'(in_ready), 0);
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        check_val("done_seen", int'(seen), 1);
        fs_exp += 2;
        @(negedge clk);
        check_val("idle_in_ready", int'(in_ready), 1);
        check_val("done_single", int'(frame_done), 0);
        repeat (3) @(negedge clk);
        check_val("done_count", done_cnt - d0, 1);
        check_val("aq_left", aq.size(), 0);
        check_val("wq_left", wq.size(), 0);
        check_val("fill_sel_end", int'(fill_sel), fs_exp % 3);
        check_val("seq_err_clean", int'(seq_err), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_in_ready"}, int'(in_ready), 1);
        check_val({tag, "_fill_sel"}, int'(fill_sel), 0);
        check_val({tag, "_a_valid"}, int'(a_valid), 0);
        check_val({tag, "_a_hcount"}, int'(a_hcount), 0);
        check_val({tag, "_a_vcount"}, int'(a_vcount), 0);
        check_val({tag, "_wb_en"}, int'(wb_en), 0);
        check_val({tag, "_wb_addr"}, int'(wb_addr), 0);
        check_val({tag, "_rd_addr"}, int'(rd_addr), 0);
        check_val({tag, "_frame_done"}, int'(frame_done), 0);
        check_val({tag, "_seq_err"}, int'(seq_err), 0);
    endtask

    initial begin
        int d0;
        do_reset();
        @(negedge clk);
        check_idle_outputs("reset");
        repeat (3) @(negedge clk);
        check_idle_outputs("idle");

        run_frame();
        run_frame();

        // Abort partway through row 2, then a clean frame must follow.
        d0 = done_cnt;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < FW; c++) send_pix(c, r, 1'b0);
        for (int c = 0; c < 4; c++) send_pix(c, 2, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        aq.delete();
        wq.delete();
        fs_exp = 0;
        @(negedge clk);
        check_idle_outputs("abort");
        repeat (30) @(negedge clk);
        check_val("abort_no_done", done_cnt - d0, 0);
        run_frame();

        // Column 3 skipped inside the first line.
        do_reset();
        send_pix(0, 0, 1'b0);
        send_pix(1, 0, 1'b0);
        send_pix(2, 0, 1'b0);
        send_pix(4, 0, 1'b0);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        @(negedge clk);
        check_val("seq_err_set", int'(seq_err), SEQ_EXP);
        repeat (5) @(negedge clk);
        check_val("seq_err_sticky", int'(seq_err), SEQ_EXP);
        do_reset();
        @(negedge clk);
        check_val("seq_err_cleared", int'(seq_err), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/line_buffer_sched.md
LINE_BUFFER_SCHED -- requirements
Module: line_buffer_sched

Interface
REQ-001 Parameter FRAME_WIDTH, default 240, sets pixels per line (columns 0..FRAME_WIDTH-1).
REQ-002 Parameter FRAME_HEIGHT, default 320, sets lines per frame (rows 0..FRAME_HEIGHT-1).
REQ-003 Parameter WB_LAG, default 3, sets the column distance between the read column and the write-back column.
REQ-004 Parameter RD_LAT, default 2, sets the line-buffer RAM read latency in cycles.
REQ-005 clk_in  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-006 rst_in  input  1  synchronous, active-high reset.
REQ-007 pix_valid_in  input  1  incoming grayscale pixel is valid this cycle.
REQ-008 hcount_in  input  11  column of the incoming pixel.
REQ-009 vcount_in  input  10  row of the incoming pixel.
REQ-010 in_ready  output  1  the block accepts input pixels this cycle.
REQ-011 fill_sel  output  2  index (0..2) of the buffer being filled with fresh pixels; (fill_sel+1) mod 3 is the B buffer and (fill_sel+2) mod 3 is the E/write-back buffer.
REQ-012 rd_addr  output  8  read column for the B and E buffers.
REQ-013 wb_addr  output  8  write-back column for the E buffer.
REQ-014 wb_en  output  1  write-back strobe for the E buffer.
REQ-015 a_valid  output  1  the B/E read data returned for a_hcount/a_vcount is valid.
REQ-016 a_hcount  output  11  column of the pixel being dithered.
REQ-017 a_vcount  output  10  row of the pixel being dithered.
REQ-018 frame_done  output  1  one-cycle pulse at end of frame.
REQ-019 seq_err  output  1  sticky input-sequence error flag.

Function
REQ-020 The FSM SHALL have states IDLE, PRIME, RUN, FLUSH, and DONE.
REQ-021 A pixel is accepted when pix_valid_in and in_ready are both 1; in_ready SHALL be 1 in IDLE, PRIME, and RUN and 0 in FLUSH and DONE.
REQ-022 IDLE->PRIME on an accepted pixel with hcount_in=0 and vcount_in=0; all other pixels accepted in IDLE SHALL be ignored.
REQ-023 A line completes on an accepted pixel with hcount_in=FRAME_WIDTH-1; fill_sel SHALL then advance 0->1->2->0 on the following edge.
REQ-024 PRIME->RUN on completion of the second line; no a_valid or wb_en SHALL be asserted in PRIME.
REQ-025 In RUN, for an accepted pixel at column c and row r: rd_addr=c in the same cycle (combinational).
REQ-026 In RUN, RD_LAT cycles after that pixel, the block SHALL assert a_valid=1 with a_hcount=c and a_vcount=r-2.
REQ-027 In RUN, wb_en=1 with wb_addr=a_hcount-WB_LAG SHALL be asserted only in cycles where a_valid=1 and a_hcount>=WB_LAG.
REQ-028 At the end of each line, the tail columns FRAME_WIDTH-WB_LAG..FRAME_WIDTH-1 SHALL be written back on the WB_LAG cycles following that line's last a_valid, before fill_sel's rotation is seen by the write path; the write path SHALL use a fill_sel value registered alongside the data.
REQ-029 RUN->FLUSH on completion of line FRAME_HEIGHT-1.
REQ-030 In FLUSH, an internal column counter SHALL sweep 0..FRAME_WIDTH-1 one column per cycle, twice, driving rd_addr, and SHALL advance fill_sel at the end of each sweep.
REQ-031 In FLUSH, the block SHALL produce a_valid, a_hcount, a_vcount (rows FRAME_HEIGHT-2 and FRAME_HEIGHT-1), and write-back exactly as in RUN.
REQ-032 FLUSH->DONE once the last write-back of the second sweep has issued; DONE SHALL last one cycle with frame_done=1, then go to IDLE.
REQ-033 Arithmetic: column subtraction SHALL never wrap; wb_addr SHALL be truncated to 8 bits after the range check.
REQ-034 Simultaneous line completion and a pending tail write-back SHALL both complete with no lost write.

Reset
REQ-035 While rst_in=1 at an edge, the block SHALL go to IDLE with fill_sel=0, wb_en=0, a_valid=0, a_hcount=0, a_vcount=0, frame_done=0, seq_err=0, and all pipelines cleared.
REQ-036 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse; the next frame SHALL start from IDLE.

Configuration
REQ-037 Macro LINE_BUFFER_SCHED_SEQ_CHECK_EN, when defined, SHALL set seq_err on any of the following:
- an accepted pixel in PRIME or RUN whose column is not the previous column+1, or whose column is not 0 after FRAME_WIDTH-1;
- a row change not at a line boundary;
- pix_valid_in=1 while in_ready=0.
seq_err SHALL be cleared only by reset.
REQ-038 Without LINE_BUFFER_SCHED_SEQ_CHECK_EN, seq_err SHALL be tied to 0 and no checker logic SHALL be synthesised.

Verification (FRAME_WIDTH=8, FRAME_HEIGHT=4 unless noted)
REQ-039 Reset, then idle -> all outputs 0, in_ready=1, fill_sel=0.
REQ-040 Stream 2 full lines -> a_valid stays 0, wb_en stays 0, fill_sel steps 0->1->2.
REQ-041 Pixel (c=5, r=2) accepted -> rd_addr=5 in the same cycle; 2 cycles later a_valid=1, a_hcount=5, a_vcount=0; wb_en=1 with wb_addr=2.
REQ-042 Full frame -> 8 wb_en pulses per output row with addresses 0..7 in order, FLUSH emits rows 2 and 3, frame_done pulses once, then IDLE.
REQ-043 Assert rst_in mid-row 2 -> next cycle in IDLE with outputs 0; a following full frame completes correctly.
REQ-044 With LINE_BUFFER_SCHED_SEQ_CHECK_EN: skip column 3 -> seq_err=1 and stays 1 until reset; without the macro -> seq_err=0.
